// File: rtl/axi_bridge_mp_if.sv
// AXI3 master-port bundle used by the bridge: full AR/R/AW/W/B signal set
// with 4-bit IDs and 32-bit data.
interface axi_bridge_mp_if #(
    parameter int ADDR_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [3:0]        wid;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_bridge_mp.sv
// SRAM-like to AXI3 bridge for NM CPU-side masters. One AR slot (multiple
// outstanding reads per master, tracked by ID = master index) and one write
// slot; fixed priority (highest index wins); reads to the word being written
// are held until the write slot drains.
module axi_bridge_mp #(
    parameter int NM         = 2,
    parameter int MAX_RD_OUT = 2,
    parameter int ADDR_W     = 32
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic [NM-1:0]        m_req_i,
    input  logic [NM-1:0]        m_wr_i,
    input  logic [2*NM-1:0]      m_size_i,
    input  logic [ADDR_W*NM-1:0] m_addr_i,
    input  logic [4*NM-1:0]      m_wstrb_i,
    input  logic [32*NM-1:0]     m_wdata_i,
    output logic [NM-1:0]        m_addr_ok_o,
    output logic [NM-1:0]        m_data_ok_o,
    output logic [32*NM-1:0]     m_rdata_o,
    axi_bridge_mp_if.master      axi
);
    localparam int CNT_W = $clog2(MAX_RD_OUT + 1);

    typedef enum logic [2:0] {W_IDLE, W_AW_W, W_W_ONLY, W_AW_ONLY, W_B} wstate_e;

    wstate_e                  wstate_q, wstate_d;
    logic [NM-1:0][CNT_W-1:0] rd_cnt_q;
    logic [NM-1:0]            wr_busy_q;
    logic [NM-1:0]            data_ok_q;
    logic [NM-1:0][31:0]      rdata_q;

    logic                     arvalid_q;
    logic [ADDR_W-1:0]        araddr_q;
    logic [3:0]               arid_q;
    logic [1:0]               arsize_q;

    logic [ADDR_W-1:0]        awaddr_q;
    logic [3:0]               awid_q;
    logic [1:0]               awsize_q;
    logic [31:0]              wdata_q;
    logic [3:0]               wstrb_q;

    logic                     awvalid, wvalid, bready;
    logic                     aw_hs, w_hs, b_hs, r_hs;

    logic [NM-1:0]            rd_gnt, wr_gnt;
    logic                     rd_any, wr_any;
    logic [3:0]               rd_idx, wr_idx;
    logic [ADDR_W-1:0]        rd_addr, wr_addr;
    logic [1:0]               rd_size, wr_size;
    logic [31:0]              wr_data;
    logic [3:0]               wr_strb;

    assign aw_hs = awvalid & axi.awready;
    assign w_hs  = wvalid & axi.wready;
    assign b_hs  = axi.bvalid & bready;
    assign r_hs  = axi.rvalid;          // rready is tied high

    // Fixed-priority arbiters: later (higher-index) eligible masters override earlier ones
    always_comb begin
        rd_gnt  = '0;
        rd_any  = 1'b0;
        rd_idx  = '0;
        rd_addr = '0;
        rd_size = '0;
        wr_gnt  = '0;
        wr_any  = 1'b0;
        wr_idx  = '0;
        wr_addr = '0;
        wr_size = '0;
        wr_data = '0;
        wr_strb = '0;
        for (int m = 0; m < NM; m++) begin
            // A read to the word sitting in the write slot would overtake it
            if (!reset && !arvalid_q && m_req_i[m] && !m_wr_i[m]
                && rd_cnt_q[m] < CNT_W'(MAX_RD_OUT) && !wr_busy_q[m]
                && !(wstate_q != W_IDLE
                     && m_addr_i[m*ADDR_W+2 +: ADDR_W-2] == awaddr_q[ADDR_W-1:2])) begin
                rd_gnt    = '0;
                rd_gnt[m] = 1'b1;
                rd_any    = 1'b1;
                rd_idx    = 4'(m);
                rd_addr   = m_addr_i[m*ADDR_W +: ADDR_W];
                rd_size   = m_size_i[2*m +: 2];
            end
            // Writes wait for the master's own reads to drain to keep data_ok in order
            if (!reset && wstate_q == W_IDLE && m_req_i[m] && m_wr_i[m]
                && rd_cnt_q[m] == '0) begin
                wr_gnt    = '0;
                wr_gnt[m] = 1'b1;
                wr_any    = 1'b1;
                wr_idx    = 4'(m);
                wr_addr   = m_addr_i[m*ADDR_W +: ADDR_W];
                wr_size   = m_size_i[2*m +: 2];
                wr_data   = m_wdata_i[32*m +: 32];
                wr_strb   = m_wstrb_i[4*m +: 4];
            end
        end
    end

    assign m_addr_ok_o = rd_gnt | wr_gnt;

    // Per-master bookkeeping: outstanding reads, write busy, completions, read data
    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_cnt_q  <= '0;
            wr_busy_q <= '0;
            data_ok_q <= '0;
            rdata_q   <= '0;
        end else begin
            for (int m = 0; m < NM; m++) begin
                if (rd_gnt[m] && !(r_hs && axi.rid == 4'(m)))
                    rd_cnt_q[m] <= rd_cnt_q[m] + CNT_W'(1);
                else if (!rd_gnt[m] && r_hs && axi.rid == 4'(m))
                    rd_cnt_q[m] <= rd_cnt_q[m] - CNT_W'(1);

                if (wr_gnt[m])
                    wr_busy_q[m] <= 1'b1;
                else if (b_hs && axi.bid == 4'(m))
                    wr_busy_q[m] <= 1'b0;

                data_ok_q[m] <= (r_hs && axi.rid == 4'(m)) || (b_hs && axi.bid == 4'(m));

                if (r_hs && axi.rid == 4'(m))
                    rdata_q[m] <= axi.rdata;
            end
        end
    end

    // AR slot: load on read grant, hold until arready
    always_ff @(posedge aclk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arsize_q  <= '0;
        end else if (!arvalid_q) begin
            if (rd_any) begin
                arvalid_q <= 1'b1;
                araddr_q  <= rd_addr;
                arid_q    <= rd_idx;
                arsize_q  <= rd_size;
            end
        end else if (axi.arready) begin
            arvalid_q <= 1'b0;
        end
    end

    // Write slot payload: captured on write grant
    always_ff @(posedge aclk) begin
        if (reset) begin
            awaddr_q <= '0;
            awid_q   <= '0;
            awsize_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (wr_any) begin
            awaddr_q <= wr_addr;
            awid_q   <= wr_idx;
            awsize_q <= wr_size;
            wdata_q  <= wr_data;
            wstrb_q  <= wr_strb;
        end
    end

    // Write slot state register
    always_ff @(posedge aclk) begin
        if (reset) wstate_q <= W_IDLE;
        else       wstate_q <= wstate_d;
    end

    // Write slot next state: AW and W may complete in either order
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:    if (wr_any) wstate_d = W_AW_W;
            W_AW_W: begin
                if (aw_hs && w_hs) wstate_d = W_B;
                else if (aw_hs)    wstate_d = W_W_ONLY;
                else if (w_hs)     wstate_d = W_AW_ONLY;
            end
            W_W_ONLY:  if (w_hs)  wstate_d = W_B;
            W_AW_ONLY: if (aw_hs) wstate_d = W_B;
            W_B:       if (b_hs)  wstate_d = W_IDLE;
            default:   wstate_d = W_IDLE;
        endcase
    end

    // Write slot outputs
    always_comb begin
        awvalid = (wstate_q == W_AW_W) || (wstate_q == W_AW_ONLY);
        wvalid  = (wstate_q == W_AW_W) || (wstate_q == W_W_ONLY);
        bready  = (wstate_q == W_B);
    end

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = {1'b0, arsize_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = 1'b1;

    assign axi.awid    = awid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = {1'b0, awsize_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid;
    assign axi.wid     = awid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid;
    assign axi.bready  = bready;

    assign m_data_ok_o = data_ok_q;
    assign m_rdata_o   = rdata_q;

    // Response status and rlast carry nothing the masters can use
    logic unused_resp;
    assign unused_resp = ^{axi.rresp, axi.bresp, axi.rlast};
endmodule

// File: doc/axi_bridge_mp.md
# axi_bridge_mp

Parametrised SRAM-like-to-AXI3 bridge joining NM CPU-side masters (instruction fetch, data access, future DMA/refill ports) to one AXI master port. It supports multiple outstanding reads per master, writes from any master, fixed-priority arbitration and read-after-write address hazard blocking. Read data is returned to the issuing master using the AXI ID. It replaces the fixed two-port, single-outstanding bridge at the CPU top level.

## Interface
- NM, 2: number of masters, 1..8; master index = AXI ID.
- MAX_RD_OUT, 2: maximum outstanding reads per master, 1..7.
- ADDR_W, 32: address width.
- aclk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- m_req  in  NM  per-master request.
- m_wr  in  NM  per-master 1 = write.
- m_size  in  2*NM  per-master size (0 = byte, 1 = half, 2 = word); master m at bits [2m+1:2m], same packing for all vectors.
- m_addr  in  ADDR_W*NM  per-master address.
- m_wstrb  in  4*NM  per-master write strobes.
- m_wdata  in  32*NM  per-master write data.
- m_addr_ok  out  NM  request accepted this cycle (combinational).
- m_data_ok  out  NM  one-cycle completion pulse.
- m_rdata  out  32*NM  last read data for each master; valid while data_ok is high, then held.
- AXI3 master port, full AR/R/AW/W/B signal set:
  - 4-bit IDs.
  - arlen/awlen = 0, arburst/awburst = 01, lock/cache/prot = 0.
  - wlast = 1, wid = awid.
  - arsize/awsize = {1'b0, size}.

## Operation
- **Per-master counters.**
  - rd_cnt[m] counts outstanding reads (width $clog2(MAX_RD_OUT+1)).
  - +1 on read grant to m, −1 on R handshake with rid == m; both in the same cycle leaves it unchanged.
  - wr_busy[m] is set on write grant to m and cleared on the B handshake with bid == m.
- **Read arbitration.** Active only when the AR slot is empty (arvalid = 0). Master m is eligible if all hold:
  - m_req & ~m_wr;
  - rd_cnt[m] < MAX_RD_OUT;
  - ~wr_busy[m];
  - no RAW hazard: not (write slot busy and m_addr[m][ADDR_W-1:2] == awaddr[ADDR_W-1:2]).
- The highest-index eligible master wins. Its addr_ok is asserted and araddr/arsize/arid are latched; arvalid rises next cycle and holds until arready.
- **Write arbitration.** Active only when the write slot is idle. Master m is eligible if m_req & m_wr & rd_cnt[m] == 0; highest index wins.
  - On grant: addr_ok is asserted; awaddr/awsize/awid/wdata/wstrb are latched.
- **Per-master ordering.** A master never has reads and a write outstanding together, so its data_ok events are in issue order.
- **Write slot FSM:** IDLE → AW_W (awvalid = wvalid = 1).
  - From AW_W, both handshakes in one cycle → B; AW only → W_ONLY; W only → AW_ONLY.
  - W_ONLY or AW_ONLY → B on the remaining handshake.
  - B → IDLE on bvalid & bready; bready = 1 only in state B.
- **Responses.**
  - rready is tied to 1.
  - On the R handshake: m_rdata[rid] ← rdata, and m_data_ok[rid] pulses the next cycle.
  - On the B handshake: m_data_ok[bid] pulses the next cycle.
  - rresp/bresp are ignored; rid/bid ≥ NM are illegal (not checked).
- A read and a write grant to different masters in the same cycle are both allowed.

## Timing
- **Reset values:**
  - all FSMs idle, counters 0;
  - arvalid = awvalid = wvalid = bready = 0, rready = 1;
  - m_addr_ok = m_data_ok = 0;
  - m_rdata, araddr, awaddr, wdata, wstrb, arid, awid, arsize, awsize = 0.
- Reset mid-transaction abandons all outstanding transactions; the AXI slave is reset with the bridge.
- **Read latency:**
  - grant at cycle T;
  - arvalid from T+1;
  - with arready at T+1 and rvalid at T+2, data_ok at T+3.
- **AR issue rate:** at most one AR every 2 cycles, because the slot must be empty to grant.
- **Write latency:** grant at T, aw/w from T+1, data_ok one cycle after the B handshake.
- **Full / blocking conditions:**
  - rd_cnt[m] == MAX_RD_OUT blocks further read grants to m until an R beat for m arrives; a grant is allowed in the same cycle the count drops.
  - A RAW hazard holds the read until the write slot returns to IDLE; the read may be granted in the IDLE cycle after B.

## Test plan
- **Single read:** NM=2, master 0 reads 0x1C00_0000, slave returns 0x1234_5678 with rid=0 → addr_ok[0] at T, arid=0, data_ok[0] one cycle after R, m_rdata[0] = 0x1234_5678.
- **Simultaneous reads:** masters 0 and 1 request reads in the same cycle → master 1 granted first (arid=1), master 0 granted two cycles later; R beats returned out of order (rid 0 then 1) → each data_ok pulses on the correct port.
- **Outstanding limit:** MAX_RD_OUT=2, master 0 issues 3 reads with R withheld → third addr_ok suppressed until the first R beat, then granted.
- **Write then RAW hazard:** master 1 writes 0xDEAD_BEEF, wstrb=0xF to 0x100 while master 0 reads 0x102 → read blocked until B; arvalid appears after the write returns to IDLE.
- **Write channel ordering:** wready asserted 3 cycles before awready → FSM passes through AW_ONLY; exactly one data_ok[1] after B.
- **Reset mid-transaction:** reset asserted while arvalid = 1 and a write is in state B → next cycle all valids 0, counters 0, no data_ok pulse.
